// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a row of NUM_DIGITS 7-segment digits.
// A valid/ready port loads packed BCD codes and decimal points into a shadow
// register. The shadow is copied to the displayed value only at a frame
// boundary while scanning, or on the next cycle while idle, so a frame never
// shows half-old, half-new digits. Each digit slot begins with one blank
// guard cycle to prevent ghosting.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_enable            1 = scan, 0 = all digits off
//   i_lz_blank          1 = blank leading zeros (digit 0 is never blanked)
//   i_load_valid        new value offered on i_bcd_in / i_dp_in
//   o_load_ready        shadow register free
//   i_bcd_in, i_dp_in   packed codes (digit i at [4i+3:4i]) and dp requests
//   o_seg, o_dp_out     segments a..g in bits 0..6, and decimal point
//   o_dig_en            one-hot digit select, or none selected
//   o_frame_done        one-cycle pulse at the end of each full scan
//
// state | meaning
// IDLE  | counters held at 0, every output unlit, loads apply next cycle
// SCAN  | slot counter running, loads apply when idx wraps to 0
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_lz_blank,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [4*NUM_DIGITS-1:0] i_bcd_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  output logic [6:0]              o_seg,
  output logic                    o_dp_out,
  output logic [NUM_DIGITS-1:0]   o_dig_en,
  output logic                    o_frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // XOR masks that turn active-high values into pin levels
  localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_POL  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_bcd;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pend;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig_en;
  logic                    r_frame_done;

  logic                    w_cnt_last;
  logic                    w_idx_last;
  logic                    w_wrap;
  logic                    w_accept;
  logic                    w_xfer;
  logic [NUM_DIGITS-1:0]   w_lz_zero;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_dig_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] i_code);
    logic [6:0] v_seg;
    case (i_code)
      4'd0:    v_seg = 7'b0111111;
      4'd1:    v_seg = 7'b0000110;
      4'd2:    v_seg = 7'b1011011;
      4'd3:    v_seg = 7'b1001111;
      4'd4:    v_seg = 7'b1100110;
      4'd5:    v_seg = 7'b1101101;
      4'd6:    v_seg = 7'b1111101;
      4'd7:    v_seg = 7'b0000111;
      4'd8:    v_seg = 7'b1111111;
      4'd9:    v_seg = 7'b1101111;
      default: v_seg = 7'b0000000;
    endcase
    return v_seg;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_enable)  w_state_nxt = SCAN;
      SCAN:    if (!i_enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_idx_last = (r_idx == IDX_LAST);
  assign w_wrap     = (r_state == SCAN) && w_cnt_last && w_idx_last;
  assign w_accept   = i_load_valid && !r_pend;
  // the wrap transfer happens even if enable drops in the same cycle
  assign w_xfer     = r_pend && (w_wrap || (r_state == IDLE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if ((r_state == SCAN) && i_enable) begin
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
      r_idx <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp_bcd   <= '0;
      r_disp_dp    <= '0;
      r_shadow_bcd <= '0;
      r_shadow_dp  <= '0;
      r_pend       <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_disp_bcd <= r_shadow_bcd;
        r_disp_dp  <= r_shadow_dp;
      end
      // accept needs pend=0 and transfer needs pend=1, so they never collide
      if (w_accept) begin
        r_shadow_bcd <= i_bcd_in;
        r_shadow_dp  <= i_dp_in;
        r_pend       <= 1'b1;
      end else if (w_xfer) begin
        r_pend <= 1'b0;
      end
    end
  end

  // w_lz_zero[k]: digit k and every digit above it hold code 0
  always_comb begin
    logic v_zero;
    v_zero    = 1'b1;
    w_lz_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_zero       = v_zero && (r_disp_bcd[4*k +: 4] == 4'd0);
      w_lz_zero[k] = v_zero;
    end
  end

  always_comb begin
    w_seg_nxt = 7'b0;
    w_dp_nxt  = 1'b0;
    w_dig_nxt = '0;
    if ((r_state == SCAN) && (r_cnt != '0)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (r_idx == IW'(k)) begin
          w_dig_nxt[k] = 1'b1;
          w_dp_nxt     = r_disp_dp[k];
          if (!(i_lz_blank && (k != 0) && w_lz_zero[k]))
            w_seg_nxt = f_decode(r_disp_bcd[4*k +: 4]);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg        <= SEG_POL;
      r_dp         <= DP_POL;
      r_dig_en     <= DIG_POL;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt ^ SEG_POL;
      r_dp         <= w_dp_nxt ^ DP_POL;
      r_dig_en     <= w_dig_nxt ^ DIG_POL;
      r_frame_done <= w_wrap && i_enable;
    end
  end

  assign o_load_ready = !r_pend;
  assign o_seg        = r_seg;
  assign o_dp_out     = r_dp;
  assign o_dig_en     = r_dig_en;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a parameterised row of 7-segment digits. It holds NUM_DIGITS packed BCD codes behind a valid/ready load port and scans one digit at a time at a programmable refresh rate. Each scan slot starts with a guard (blank) cycle to prevent ghosting, new loads apply only at frame boundaries to prevent tearing, and leading-zero suppression is optional. It sits between the counter/datapath logic and the board's segment and digit-select pins, and replaces the single-digit combinational BCD decoder.

## Interface
- NUM_DIGITS, 4: digit count, 1..8; digit 0 is least significant.
- REFRESH_DIV, 1000: clocks per digit slot, ≥2.
- SEG_ACTIVE_LOW, 0: 1 means seg/dp_out drive 0 to light a segment.
- DIG_ACTIVE_LOW, 1: 1 means dig_en drives 0 to select a digit.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scanning; 0 = all digits off.
- lz_blank  in  1  1 = suppress leading zeros.
- load_valid  in  1  new display value offered.
- load_ready  out  1  shadow register free; a load is accepted when valid && ready.
- bcd_in  in  4*NUM_DIGITS  packed codes; digit i is at bits [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- dp_out  out  1  decimal point of the selected digit.
- dig_en  out  NUM_DIGITS  one-hot digit select, or none selected.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- **Registers:**
  - disp (displayed BCD+dp).
  - shadow (pending BCD+dp) and pend flag.
  - cnt: 0..REFRESH_DIV-1.
  - idx: 0..NUM_DIGITS-1.
  - state: IDLE or SCAN.
- **Decode (active-high before polarity):**
  - 0=a,b,c,d,e,f
  - 1=b,c
  - 2=a,b,d,e,g
  - 3=a,b,c,d,g
  - 4=b,c,f,g
  - 5=a,c,d,f,g
  - 6=a,c,d,e,f,g
  - 7=a,b,c
  - 8=all
  - 9=a,b,c,d,f,g
  - Codes 10–15 produce all segments off.
- **Load handshake:**
  - load_ready = !pend.
  - An accepted load copies bcd_in/dp_in into shadow and sets pend.
  - In SCAN: shadow → disp and pend cleared on the cycle idx wraps from NUM_DIGITS-1 to 0.
  - In IDLE: shadow → disp on the cycle after acceptance.
- **IDLE:**
  - cnt=0, idx=0; all digits and segments inactive.
  - enable=1 → SCAN next cycle.
- **SCAN:**
  - cnt increments each cycle.
  - At cnt==REFRESH_DIV-1: cnt→0 and idx→idx+1, wrapping NUM_DIGITS-1→0.
  - enable=0 → IDLE next cycle, from any point, with no wait for the frame end.
- **Guard:**
  - When cnt==0, all dig_en are inactive and seg/dp_out are off.
  - Otherwise dig_en[idx] is active, and seg/dp_out show disp digit idx.
- **Leading-zero suppression:**
  - With lz_blank=1, digit k (k≥1) is blanked (segments off) when disp digit k and all digits above it equal 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp if requested.
  - A code of 10–15 counts as non-zero for suppression.
- **frame_done:** pulses for the cycle in which idx wraps to 0. It never pulses in IDLE.
- **Polarity:** SEG_ACTIVE_LOW inverts seg and dp_out; DIG_ACTIVE_LOW inverts dig_en. "Off/inactive" always means the unlit level.

## Timing
- seg, dp_out, dig_en and frame_done are registered: they reflect state/cnt/idx/disp from the previous cycle, a one-cycle output latency.
- **Reset (asynchronous):**
  - state=IDLE, cnt=0, idx=0, disp=all 0, dp=0, pend=0.
  - load_ready=1, frame_done=0.
  - dig_en all inactive; seg and dp_out off, at the polarity-adjusted levels.
- Reset asserted mid-scan or mid-load clears pend, so the pending value is lost.
- **Slot and frame:**
  - Slot length = REFRESH_DIV cycles: 1 guard cycle plus REFRESH_DIV-1 lit cycles.
  - Frame = NUM_DIGITS × REFRESH_DIV cycles.
- **Load latency in SCAN:**
  - Worst case is one frame from acceptance to display.
  - The new value first appears in the slot-0 output of the following frame.
- **Simultaneous events:**
  - When the transfer and a new load_valid fall in the same cycle, the new load is not accepted: load_ready is still 0 that cycle. load_ready rises the next cycle.
  - When enable falls on the wrap cycle, the transfer still happens. frame_done does not pulse because the state leaves SCAN.
- NUM_DIGITS=1: idx stays at 0, and frame_done pulses every REFRESH_DIV cycles.

## Test plan
Bench configuration for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.

- **Reset and idle:** rst_n=0 then 1, with enable=0 → seg=7'h00, dp_out=0, dig_en=4'hF, load_ready=1, frame_done=0 on every cycle.
- **Basic scan:**
  - Stimulus: load bcd_in=16'h1234 in IDLE, then enable=1.
  - Each slot shows one guard cycle with dig_en=4'hF, then 3 cycles of dig_en=4'hE showing "4" (seg=7'b1100110).
  - The following slots show 4'hD with "3", 4'hB with "2", and 4'h7 with "1".
  - frame_done pulses every 16 cycles.
- **Tear-free load:**
  - Stimulus: mid-frame, load 16'h5678 with load_valid held high.
  - load_ready drops after acceptance; the old digits finish the frame.
  - At the wrap, disp becomes 5678 and load_ready returns to 1 one cycle later.
  - A second valid held during the pending period is accepted only after that.
- **Leading-zero suppression:**
  - Stimulus: bcd_in=16'h0040, lz_blank=1, dp_in=4'b1000.
  - Digit 3 is blank except dp_out=1, digit 2 is blank, digit 1 shows "4", digit 0 shows "0".
  - With lz_blank=0, digit 3 and digit 2 show "0".
- **Invalid codes and polarity:**
  - bcd_in=16'hFA09 → digits 3 and 2 blank, with no suppression of digits below them.
  - Rerun with SEG_ACTIVE_LOW=1: digit 0 "9" gives seg=7'b0010000.
- **Mid-operation events:**
  - enable=0 mid-slot 2 → next cycle is all-off IDLE, and re-enable restarts at slot 0 with a guard cycle.
  - rst_n=0 while pend=1 → pend cleared, disp=0, and outputs immediately inactive.
